// File: rtl/cc_bus_fifo.sv
// Synchronous FIFO with registered read data and an async active-high reset.
// Define CC_BUS_FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow outputs.
module cc_bus_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
`ifdef CC_BUS_FIFO_ERROR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  rd_acc, wr_acc;

  // A write into a full FIFO is allowed when a read frees a slot on the same edge.
  always_comb begin
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    rd_acc = rd_en && (count_q != '0);
    wr_acc = wr_en && ((count_q != CW'(DEPTH)) || rd_acc);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is not reset; stale entries are never read before being rewritten.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);

`ifdef CC_BUS_FIFO_ERROR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_en && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (rd_en && !rd_acc) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_cc_bus_fifo.sv
// Directed bench for cc_bus_fifo (WIDTH=4, DEPTH_LOG2=2): vector table plus
// hand sequences for mid-cycle reset. Honours CC_BUS_FIFO_ERROR_FLAGS_EN.
module tb_cc_bus_fifo;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_data;
  logic       full;
  logic       empty;
  logic [2:0] count;
`ifdef CC_BUS_FIFO_ERROR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  cc_bus_fifo #(.WIDTH(4), .DEPTH_LOG2(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
`ifdef CC_BUS_FIFO_ERROR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] d;
    logic [3:0] erd;
    logic [2:0] ecnt;
    logic       eovf;
    logic       eudf;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic s_ovf   = 1'b0;
  logic s_udf   = 1'b0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    else
      n_pass++;
  endtask

  task automatic add(input logic we, input logic re, input logic [3:0] d,
                     input logic [3:0] erd, input logic [2:0] ecnt);
    vec_t v;
    v.we = we; v.re = re; v.d = d; v.erd = erd; v.ecnt = ecnt;
    v.eovf = s_ovf; v.eudf = s_udf;
    vecs.push_back(v);
  endtask

  task automatic check_state(input int idx, input logic [3:0] erd,
                             input logic [2:0] ecnt, input logic eovf,
                             input logic eudf);
    chk("rd_data", idx, 32'(rd_data), 32'(erd));
    chk("count",   idx, 32'(count),   32'(ecnt));
    chk("full",    idx, 32'(full),    32'(ecnt == 3'd4));
    chk("empty",   idx, 32'(empty),   32'(ecnt == 3'd0));
`ifdef CC_BUS_FIFO_ERROR_FLAGS_EN
    chk("overflow",  idx, 32'(overflow),  32'(eovf));
    chk("underflow", idx, 32'(underflow), 32'(eudf));
`else
    if (eovf === 1'bx || eudf === 1'bx) $display("note: unknown flag expectation");
`endif
  endtask

  initial begin
    // fill 1..4, then overflow write of 5
    add(1, 0, 4'd1, 4'd0, 3'd1);
    add(1, 0, 4'd2, 4'd0, 3'd2);
    add(1, 0, 4'd3, 4'd0, 3'd3);
    add(1, 0, 4'd4, 4'd0, 3'd4);
    s_ovf = 1'b1;
    add(1, 0, 4'd5, 4'd0, 3'd4);
    // drain: 5 must be absent
    add(0, 1, 4'd0, 4'd1, 3'd3);
    add(0, 1, 4'd0, 4'd2, 3'd2);
    add(0, 1, 4'd0, 4'd3, 3'd1);
    add(0, 1, 4'd0, 4'd4, 3'd0);
    // underflow: read on empty with concurrent write of 7
    s_udf = 1'b1;
    add(1, 1, 4'd7, 4'd4, 3'd1);
    add(0, 1, 4'd0, 4'd7, 3'd0);
    // simultaneous read/write at full
    add(1, 0, 4'd1, 4'd7, 3'd1);
    add(1, 0, 4'd2, 4'd7, 3'd2);
    add(1, 0, 4'd3, 4'd7, 3'd3);
    add(1, 0, 4'd4, 4'd7, 3'd4);
    add(1, 1, 4'd9, 4'd1, 3'd4);
    add(0, 1, 4'd0, 4'd2, 3'd3);
    add(0, 1, 4'd0, 4'd3, 3'd2);
    add(0, 1, 4'd0, 4'd4, 3'd1);
    add(0, 1, 4'd0, 4'd9, 3'd0);
    // wrap-around: interleaved write/read pairs 0..9
    for (int i = 0; i < 10; i++) begin
      add(1, 0, 4'(i), (i == 0) ? 4'd9 : 4'(i - 1), 3'd1);
      add(0, 1, 4'd0, 4'(i), 3'd0);
    end

    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 4'd0;
    #1;
    check_state(-1, 4'd0, 3'd0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      wr_en = vecs[i].we; rd_en = vecs[i].re; wr_data = vecs[i].d;
      @(posedge clk); #1;
      check_state(i, vecs[i].erd, vecs[i].ecnt, vecs[i].eovf, vecs[i].eudf);
    end

    // mid-cycle reset with 3 words stored and rd_data=9
    wr_en = 1'b1; rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 4'(i + 11);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    chk("pre_reset_count", 100, 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check_state(101, 4'd0, 3'd0, 1'b0, 1'b0);

    // requests ignored while reset held across an edge
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'd6;
    @(posedge clk); #1;
    check_state(102, 4'd0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0; rd_en = 1'b0; wr_data = 4'd5;
    @(posedge clk); #1;
    check_state(103, 4'd0, 3'd1, 1'b0, 1'b0);
    wr_en = 1'b0; rd_en = 1'b1;
    @(posedge clk); #1;
    check_state(104, 4'd5, 3'd0, 1'b0, 1'b0);
    rd_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
